// File: rtl/tour_cmd.sv
// Command sequencer in front of the command processor: passes UART commands through
// when idle, or replays a knight's tour as vertical/horizontal command pairs.
module tour_cmd #(
  parameter int NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] WAIT_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] WAIT_H = 3'd4;

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  logic [2:0]  state, nxt_state;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;

  assign last_move = (mv_indx == LAST_IDX);

  // Knight move decode; anything not one-hot becomes zero-square commands.
  always_comb begin
    vert_cmd = 16'h2000;
    horz_cmd = 16'h3000;
    case (move)
      8'h01: begin vert_cmd = 16'h2002; horz_cmd = 16'h33F1; end
      8'h02: begin vert_cmd = 16'h2002; horz_cmd = 16'h3BF1; end
      8'h04: begin vert_cmd = 16'h2001; horz_cmd = 16'h33F2; end
      8'h08: begin vert_cmd = 16'h27F1; horz_cmd = 16'h33F2; end
      8'h10: begin vert_cmd = 16'h27F2; horz_cmd = 16'h33F1; end
      8'h20: begin vert_cmd = 16'h27F2; horz_cmd = 16'h3BF1; end
      8'h40: begin vert_cmd = 16'h2001; horz_cmd = 16'h3BF2; end
      8'h80: begin vert_cmd = 16'h27F1; horz_cmd = 16'h3BF2; end
      default: ;
    endcase
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (start_tour)  nxt_state = VERT;
      VERT:    if (clr_cmd_rdy) nxt_state = WAIT_V;
      WAIT_V:  if (send_resp)   nxt_state = HORZ;
      HORZ:    if (clr_cmd_rdy) nxt_state = WAIT_H;
      WAIT_H:  if (send_resp)   nxt_state = last_move ? IDLE : VERT;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state <= nxt_state;
      if (state == IDLE && start_tour)
        mv_indx <= '0;
      else if (state == WAIT_H && send_resp && !last_move)
        mv_indx <= mv_indx + 5'd1;
    end
  end

  // The UART side is only connected while idle; during a tour its command waits.
  always_comb begin
    cmd              = cmd_UART;
    cmd_rdy          = cmd_rdy_UART;
    clr_cmd_rdy_UART = clr_cmd_rdy;
    resp             = 8'h5A;
    case (state)
      IDLE: resp = 8'hA5;
      VERT: begin
        cmd = vert_cmd; cmd_rdy = 1'b1; clr_cmd_rdy_UART = 1'b0;
      end
      WAIT_V: begin
        cmd = vert_cmd; cmd_rdy = 1'b0; clr_cmd_rdy_UART = 1'b0;
      end
      HORZ: begin
        cmd = horz_cmd; cmd_rdy = 1'b1; clr_cmd_rdy_UART = 1'b0;
      end
      WAIT_H: begin
        cmd = horz_cmd; cmd_rdy = 1'b0; clr_cmd_rdy_UART = 1'b0;
        resp = last_move ? 8'hA5 : 8'h5A;
      end
      default: begin
        cmd_rdy = 1'b0; clr_cmd_rdy_UART = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tour_cmd.sv
// Self-checking bench for tour_cmd: drives the command-processor side and compares
// every tour command against a geometric model of the knight moves.
module tb_tour_cmd;
  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic [7:0] tour_mem [32];
  int checks = 0;
  int errors = 0;
  int dy_tab [8] = '{2, 2, 1, -1, -2, -2, 1, -1};
  int dx_tab [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};

  always #5 clk = ~clk;

  assign move = tour_mem[mv_indx];

  tour_cmd #(.NUM_MOVES(NUM_MOVES)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .clr_cmd_rdy_UART(clr_cmd_rdy_UART), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit st, input bit clr, input bit sr);
    start_tour  = st;
    clr_cmd_rdy = clr;
    send_resp   = sr;
    #1;
  endtask

  // Vertical leg first (N or S), then horizontal (W or E), squares = |delta|.
  function automatic void modelLegs(input logic [7:0] m, output logic [15:0] v,
                                    output logic [15:0] h);
    int b = 0;
    int dy, dx;
    v = 16'h2000;
    h = 16'h3000;
    if ($countones(m) == 1) begin
      for (int i = 0; i < 8; i++) if (m[i]) b = i;
      dy = dy_tab[b];
      dx = dx_tab[b];
      v = {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'(dy > 0 ? dy : -dy)};
      h = {4'h3, (dx < 0) ? 8'h3F : 8'hBF, 4'(dx > 0 ? dx : -dx)};
    end
  endfunction

  task automatic doLeg(input logic [15:0] exp_cmd, input int idx,
                       input logic [7:0] wait_resp, input bit combo);
    int hold = $urandom_range(0, 2);
    int w = combo ? $urandom_range(1, 2) : $urandom_range(0, 2);
    for (int d = 0; d < hold; d++) begin
      applyStimulus(1'b0, 1'b0, d == 0);
      checkOutput("leg_rdy", 16'(cmd_rdy), 16'h1);
      checkOutput("leg_cmd", cmd, exp_cmd);
      checkOutput("leg_idx", 16'(mv_indx), 16'(idx));
      cyc();
    end
    applyStimulus(1'b0, 1'b1, combo);
    checkOutput("clr_rdy", 16'(cmd_rdy), 16'h1);
    checkOutput("clr_cmd", cmd, exp_cmd);
    checkOutput("clr_uart_blocked", 16'(clr_cmd_rdy_UART), 16'h0);
    checkOutput("leg_resp", 16'(resp), 16'h5A);
    cyc();
    for (int d = 0; d < w; d++) begin
      applyStimulus(d == 0, d == 0, 1'b0);
      checkOutput("wait_rdy", 16'(cmd_rdy), 16'h0);
      checkOutput("wait_resp", 16'(resp), 16'(wait_resp));
      checkOutput("wait_idx", 16'(mv_indx), 16'(idx));
      cyc();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("wait_rdy", 16'(cmd_rdy), 16'h0);
    checkOutput("wait_resp", 16'(resp), 16'(wait_resp));
    cyc();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic runMove(input int idx, input bit combo);
    logic [15:0] v, h;
    modelLegs(tour_mem[idx], v, h);
    doLeg(v, idx, 8'h5A, combo);
    doLeg(h, idx, (idx == NUM_MOVES - 1) ? 8'hA5 : 8'h5A, 1'b0);
    if (idx < NUM_MOVES - 1) begin
      checkOutput("next_idx", 16'(mv_indx), 16'(idx + 1));
      checkOutput("next_resp", 16'(resp), 16'h5A);
    end else begin
      checkOutput("end_idx", 16'(mv_indx), 16'(idx));
      checkOutput("end_resp", 16'(resp), 16'hA5);
      checkOutput("end_rdy", 16'(cmd_rdy), 16'(cmd_rdy_UART));
      checkOutput("end_cmd", cmd, cmd_UART);
    end
  endtask

  task automatic startTour();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_resp", 16'(resp), 16'hA5);
    cyc();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("start_idx", 16'(mv_indx), 16'h0);
  endtask

  task automatic fillTour();
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'(1 << $urandom_range(0, 7));
  endtask

  initial begin
    logic [15:0] v, h;
    rst_n = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'h0; cmd_rdy_UART = 1'b0;
    for (int i = 0; i < 32; i++) tour_mem[i] = 8'h00;
    #3;
    checkOutput("rst_idx", 16'(mv_indx), 16'h0);
    checkOutput("rst_resp", 16'(resp), 16'hA5);
    checkOutput("rst_rdy", 16'(cmd_rdy), 16'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // UART pass-through while idle
    cmd_UART = 16'h2A13; cmd_rdy_UART = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pt_cmd", cmd, 16'h2A13);
    checkOutput("pt_rdy", 16'(cmd_rdy), 16'h1);
    checkOutput("pt_resp", 16'(resp), 16'hA5);
    checkOutput("pt_clr_idle", 16'(clr_cmd_rdy_UART), 16'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("pt_clr", 16'(clr_cmd_rdy_UART), 16'h1);
    cyc();
    applyStimulus(1'b0, 1'b0, 1'b0);
    cmd_rdy_UART = 1'b0;

    // Full tour covering all eight encodings, UART command arriving mid-tour
    fillTour();
    for (int b = 0; b < 8; b++) tour_mem[b] = 8'(1 << b);
    startTour();
    checkOutput("first_vert", cmd, 16'h2002);
    for (int i = 0; i < NUM_MOVES; i++) begin
      if (i == 10) begin
        cmd_UART = 16'hC0DE;
        cmd_rdy_UART = 1'b1;
      end
      runMove(i, (i % 3) == 1);
    end
    checkOutput("post_cmd", cmd, 16'hC0DE);
    checkOutput("post_rdy", 16'(cmd_rdy), 16'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("post_clr", 16'(clr_cmd_rdy_UART), 16'h1);
    cyc();
    cmd_rdy_UART = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Non-one-hot moves
    fillTour();
    tour_mem[0] = 8'h00;
    tour_mem[1] = 8'h03;
    startTour();
    checkOutput("zero_vert", cmd, 16'h2000);
    for (int i = 0; i < NUM_MOVES; i++) runMove(i, 1'b0);

    // Asynchronous reset in HORZ of move 5, then restart
    fillTour();
    startTour();
    for (int i = 0; i < 5; i++) runMove(i, 1'b0);
    modelLegs(tour_mem[5], v, h);
    doLeg(v, 5, 8'h5A, 1'b0);
    checkOutput("horz5_cmd", cmd, h);
    checkOutput("horz5_rdy", 16'(cmd_rdy), 16'h1);
    cmd_UART = 16'($urandom);
    cmd_rdy_UART = 1'b1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_idx", 16'(mv_indx), 16'h0);
    checkOutput("arst_rdy", 16'(cmd_rdy), 16'h1);
    checkOutput("arst_cmd", cmd, cmd_UART);
    checkOutput("arst_resp", 16'(resp), 16'hA5);
    cyc();
    rst_n = 1'b1;
    cmd_rdy_UART = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("arst_rdy_low", 16'(cmd_rdy), 16'h0);
    startTour();
    runMove(0, 1'b0);
    runMove(1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
